// File: rtl/select_encode_regfile.sv
// Register file R0-R15 with IR-field select decode, one-hot read strobes and
// sign-extended constant for the bus multiplexer.
module select_encode_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int C_W    = 19
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [31:0]             IR,
  input  logic                    Gra,
  input  logic                    Grb,
  input  logic                    Grc,
  input  logic                    Rin,
  input  logic                    Rout,
  input  logic                    BAout,
  input  logic [DATA_W-1:0]       BusMuxout,
  output logic [NREGS*DATA_W-1:0] reg_flat,
  output logic [NREGS-1:0]        R_out_sel,
  output logic [DATA_W-1:0]       C_sign_extended,
  output logic                    wr_valid,
  output logic [3:0]              wr_idx,
  output logic                    sel_err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        idx;
  logic [1:0]        g_cnt;
  logic              sel_ok;
  logic              multi_sel;
  logic [NREGS-1:0]  dec;
  logic              unused_ir;

  // Opcode bits are not used by this block.
  assign unused_ir = ^IR[31:27];

  assign g_cnt     = {1'b0, Gra} + {1'b0, Grb} + {1'b0, Grc};
  assign sel_ok    = (g_cnt == 2'd1);
  assign multi_sel = (g_cnt >= 2'd2);

  always_comb begin
    idx = 4'd0;
    if (Gra)      idx = IR[26:23];
    else if (Grb) idx = IR[22:19];
    else if (Grc) idx = IR[18:15];
  end

  assign dec = sel_ok ? (NREGS'(1) << idx) : '0;

  // Strobes are level-qualified each cycle: Rin writes at the edge, Rout/BAout
  // read combinationally; an ambiguous select suppresses both.
  assign R_out_sel = dec & {NREGS{Rout | BAout}};

  assign C_sign_extended = {{(DATA_W-C_W){IR[C_W-1]}}, IR[C_W-1:0]};

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_flat[i*DATA_W +: DATA_W] = regs[i];
    end
    if (BAout) reg_flat[DATA_W-1:0] = '0;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_valid <= 1'b0;
      wr_idx   <= 4'd0;
      sel_err  <= 1'b0;
    end else begin
      if (Rin && sel_ok) begin
        regs[idx] <= BusMuxout;
        wr_valid  <= 1'b1;
        wr_idx    <= idx;
      end else begin
        wr_valid  <= 1'b0;
      end
      if (multi_sel && (Rin || Rout || BAout)) sel_err <= 1'b1;
    end
  end

endmodule
